// File: rtl/pim_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pim_mem_sequencer
//  Description : Sequences a processing-in-memory operation over a local
//                word memory. It loads two N x N operand matrices from
//                memory into flat operand buffers, hands them to an external
//                compute engine, then stores the N x N result back to memory.
//                A host port gives registered reads at all times and writes
//                while the sequencer is idle.
//  Option      : define PIM_MEM_CYCLE_COUNT_EN to build the operation cycle
//                counter (cyc_count); otherwise cyc_count is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module pim_mem_sequencer #(
    parameter int WIDTH     = 16,
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = 1024,
    parameter int MAX_N     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [$clog2(MAX_N+1)-1:0]       mat_n,
    input  logic [ADDR_W-1:0]                src1_addr,
    input  logic [ADDR_W-1:0]                src2_addr,
    input  logic [ADDR_W-1:0]                dst_addr,
    input  logic                             host_we,
    input  logic [ADDR_W-1:0]                host_addr,
    input  logic [WIDTH-1:0]                 host_wdata,
    output logic [WIDTH-1:0]                 host_rdata,
    output logic                             pim_start,
    output logic [MAX_N*MAX_N*WIDTH-1:0]     pim_a,
    output logic [MAX_N*MAX_N*WIDTH-1:0]     pim_b,
    input  logic [MAX_N*MAX_N*WIDTH-1:0]     pim_result,
    input  logic                             pim_done,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic [31:0]                      cyc_count
);

    localparam int NW  = $clog2(MAX_N + 1);
    localparam int KW  = $clog2(MAX_N * MAX_N + 1);
    localparam int AW1 = ADDR_W + 1;

    localparam logic [AW1-1:0] c_depth = AW1'(MEM_DEPTH);
    localparam logic [NW-1:0]  c_max_n = NW'(MAX_N);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_STORE   = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t              r_state;
    logic [KW-1:0]       r_k;
    logic [KW-1:0]       r_nn;
    logic [ADDR_W-1:0]   r_src1;
    logic [ADDR_W-1:0]   r_src2;
    logic [ADDR_W-1:0]   r_dst;

    logic [WIDTH-1:0]    mem [MEM_DEPTH];

    // Request validation is done one bit wider than the address so that a
    // region running past the top of memory is caught instead of wrapping.
    logic [AW1-1:0]      w_req_nn;
    logic                w_req_ok;
    logic                w_accept;

    logic [ADDR_W-1:0]   w_rd1_addr;
    logic [ADDR_W-1:0]   w_rd2_addr;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [WIDTH-1:0]    w_rd1_data;
    logic [WIDTH-1:0]    w_rd2_data;
    logic [WIDTH-1:0]    w_res_elem;

    assign w_req_nn = AW1'(mat_n) * AW1'(mat_n);
    assign w_req_ok = (mat_n != '0) && (mat_n <= c_max_n)
                   && ({1'b0, src1_addr} + w_req_nn <= c_depth)
                   && ({1'b0, src2_addr} + w_req_nn <= c_depth)
                   && ({1'b0, dst_addr}  + w_req_nn <= c_depth);
    assign w_accept = (r_state == S_IDLE) && start && w_req_ok;

    // Accepted regions never cross the top of memory, so the ADDR_W-bit
    // element addresses below cannot wrap.
    assign w_rd1_addr = r_src1 + ADDR_W'(r_k);
    assign w_rd2_addr = r_src2 + ADDR_W'(r_k);
    assign w_wr_addr  = r_dst  + ADDR_W'(r_k);
    assign w_rd1_data = mem[w_rd1_addr];
    assign w_rd2_data = mem[w_rd2_addr];
    assign w_res_elem = pim_result[int'(r_k)*WIDTH +: WIDTH];

    // Sequencer: request check, operand load, compute handshake, result store.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_nn      <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_dst     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            pim_start <= 1'b0;
            pim_a     <= '0;
            pim_b     <= '0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            pim_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_req_ok) begin
                            r_nn    <= KW'(w_req_nn);
                            r_src1  <= src1_addr;
                            r_src2  <= src2_addr;
                            r_dst   <= dst_addr;
                            r_k     <= '0;
                            // Elements beyond N*N stay zero for this operation.
                            pim_a   <= '0;
                            pim_b   <= '0;
                            busy    <= 1'b1;
                            r_state <= S_LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    pim_a[int'(r_k)*WIDTH +: WIDTH] <= w_rd1_data;
                    pim_b[int'(r_k)*WIDTH +: WIDTH] <= w_rd2_data;
                    r_k <= r_k + KW'(1);
                    if (r_k == r_nn - KW'(1)) begin
                        pim_start <= 1'b1;
                        r_state   <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (pim_done) begin
                        r_k     <= '0;
                        r_state <= S_STORE;
                    end
                end
                S_STORE: begin
                    r_k <= r_k + KW'(1);
                    if (r_k == r_nn - KW'(1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Memory: host writes only while idle, result writes during STORE; reset
    // blocks writes but never clears contents. Host read port is registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_IDLE && host_we) begin
                mem[host_addr] <= host_wdata;
            end else if (r_state == S_STORE) begin
                mem[w_wr_addr] <= w_res_elem;
            end
        end
        host_rdata <= mem[host_addr];
    end

`ifdef PIM_MEM_CYCLE_COUNT_EN
    logic [31:0] r_cyc;

    // Counts the accepting cycle plus every non-idle cycle up to and
    // including the done pulse, then holds until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc <= '0;
        end else if (w_accept) begin
            r_cyc <= 32'd1;
        end else if (r_state != S_IDLE) begin
            r_cyc <= r_cyc + 32'd1;
        end
    end

    assign cyc_count = r_cyc;
`else
    assign cyc_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pim_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pim_mem_sequencer
//  Description : Directed self-checking bench for pim_mem_sequencer. The
//                compute engine is modelled as element-wise A+B with a
//                programmable pim_done latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pim_mem_sequencer;

    localparam int WIDTH     = 16;
    localparam int ADDR_W    = 10;
    localparam int MEM_DEPTH = 1024;
    localparam int MAX_N     = 4;
    localparam int EW        = MAX_N * MAX_N * WIDTH;

`ifdef PIM_MEM_CYCLE_COUNT_EN
    localparam logic [31:0] EXP_CYC = 32'd16;
`else
    localparam logic [31:0] EXP_CYC = 32'd0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [2:0]        mat_n = '0;
    logic [ADDR_W-1:0] src1 = '0, src2 = '0, dst = '0;
    logic              host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [WIDTH-1:0]  host_wdata = '0;
    logic [WIDTH-1:0]  host_rdata;
    logic              pim_start;
    logic [EW-1:0]     pim_a, pim_b, pim_result;
    logic              pim_done;
    logic              resp_done = 1'b0, man_done = 1'b0;
    logic              busy, done, err;
    logic [31:0]       cyc_count;

    int n_cmp = 0, n_bad = 0;
    int done_cnt = 0, err_cnt = 0, pstart_cnt = 0;
    bit auto_resp = 1'b1;
    int resp_delay = 5;

    always #5 clk = ~clk;

    assign pim_done = resp_done | man_done;

    pim_mem_sequencer #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .MAX_N(MAX_N)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mat_n(mat_n),
        .src1_addr(src1), .src2_addr(src2), .dst_addr(dst),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .pim_start(pim_start),
        .pim_a(pim_a), .pim_b(pim_b), .pim_result(pim_result),
        .pim_done(pim_done), .busy(busy), .done(done), .err(err),
        .cyc_count(cyc_count)
    );

    // Compute engine model: element-wise sum of the operand buffers.
    always_comb begin
        pim_result = '0;
        for (int e = 0; e < MAX_N * MAX_N; e++)
            pim_result[e*WIDTH +: WIDTH] = pim_a[e*WIDTH +: WIDTH] + pim_b[e*WIDTH +: WIDTH];
    end

    // Pulse counters, sampled on the clock edge that registers them.
    always @(posedge clk) begin
        if (done)      done_cnt++;
        if (err)       err_cnt++;
        if (pim_start) pstart_cnt++;
    end

    // Automatic responder: pim_done is seen by the DUT resp_delay cycles after pim_start.
    initial forever begin
        @(posedge clk); #1;
        if (auto_resp && pim_start) begin
            repeat (resp_delay) @(posedge clk);
            #1 resp_done = 1'b1;
            @(posedge clk); #1 resp_done = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mem_wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        tick();
        host_we = 1'b0;
    endtask

    task automatic mem_rd(input logic [ADDR_W-1:0] a, output logic [WIDTH-1:0] d);
        host_addr = a;
        tick();
        d = host_rdata;
    endtask

    task automatic mem_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] exp);
        logic [WIDTH-1:0] d;
        mem_rd(a, d);
        check(tag, 32'(d), 32'(exp));
    endtask

    task automatic issue(input logic [2:0] n, input logic [ADDR_W-1:0] s1,
                         input logic [ADDR_W-1:0] s2, input logic [ADDR_W-1:0] d);
        mat_n = n; src1 = s1; src2 = s2; dst = d; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int d0, e0, p0;
        bit seen;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_pim_start", 32'(pim_start), 0);
        check("rst_cyc", cyc_count, 0);
        check("rst_pim_a", 32'(|pim_a), 0);
        check("rst_pim_b", 32'(|pim_b), 0);
        rst = 1'b0;
        tick();

        // preload mem[i] = i for the working window
        for (int i = 0; i < 64; i++) mem_wr(ADDR_W'(i), WIDTH'(i));

        // ---- basic 2x2 add: A=mem[0..3], B=mem[16..19] -> mem[32..35] ----
        d0 = done_cnt; e0 = err_cnt;
        issue(3'd2, 10'd0, 10'd16, 10'd32);
        check("op1_busy", 32'(busy), 1);
        wait_done(100, "op1_done_seen");
        check("op1_busy_at_done", 32'(busy), 0);
        check("op1_pim_a_lo", pim_a[31:0], 32'h0001_0000);
        check("op1_pim_a_hi", pim_a[63:32], 32'h0003_0002);
        check("op1_pim_a_zero", 32'(|pim_a[EW-1:64]), 0);
        check("op1_pim_b_lo", pim_b[31:0], 32'h0011_0010);
        tick();
        check("op1_done_count", 32'(done_cnt - d0), 1);
        check("op1_err_count", 32'(err_cnt - e0), 0);
        check("op1_cyc_count", cyc_count, EXP_CYC);
        mem_chk("op1_mem32", 10'd32, 16'd16);
        mem_chk("op1_mem33", 10'd33, 16'd18);
        mem_chk("op1_mem34", 10'd34, 16'd20);
        mem_chk("op1_mem35", 10'd35, 16'd22);
        check("op1_cyc_hold", cyc_count, EXP_CYC);

        // ---- invalid requests: N=0, N=5, src1 region past the top ----
        e0 = err_cnt; d0 = done_cnt;
        issue(3'd0, 10'd0, 10'd16, 10'd32);
        check("inv0_err", 32'(err), 1);
        check("inv0_busy", 32'(busy), 0);
        tick();
        check("inv0_err_pulse", 32'(err), 0);
        issue(3'd5, 10'd0, 10'd16, 10'd32);
        check("inv5_err", 32'(err), 1);
        check("inv5_busy", 32'(busy), 0);
        tick();
        issue(3'd2, 10'd1022, 10'd16, 10'd32);
        check("invaddr_err", 32'(err), 1);
        check("invaddr_busy", 32'(busy), 0);
        tick(); tick();
        check("inv_err_count", 32'(err_cnt - e0), 3);
        check("inv_done_count", 32'(done_cnt - d0), 0);
        mem_chk("inv_mem32", 10'd32, 16'd16);
        mem_chk("inv_mem0", 10'd0, 16'd0);

        // ---- boundary: dst region ends exactly at the top of memory ----
        e0 = err_cnt;
        issue(3'd2, 10'd0, 10'd16, 10'd1020);
        wait_done(100, "edge_done_seen");
        tick();
        check("edge_err_count", 32'(err_cnt - e0), 0);
        mem_chk("edge_mem1020", 10'd1020, 16'd16);
        mem_chk("edge_mem1023", 10'd1023, 16'd22);

        // ---- start held high for the whole operation ----
        d0 = done_cnt; e0 = err_cnt;
        mat_n = 3'd2; src1 = 10'd0; src2 = 10'd16; dst = 10'd36; start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check("hold_done_seen", 32'(seen), 1);
        repeat (4) tick();
        check("hold_done_count", 32'(done_cnt - d0), 1);
        check("hold_err_count", 32'(err_cnt - e0), 0);
        check("hold_busy", 32'(busy), 0);
        mem_chk("hold_mem36", 10'd36, 16'd16);

        // ---- reset during the second STORE cycle, N=3, dst=40 ----
        auto_resp = 1'b0;
        d0 = done_cnt;
        issue(3'd3, 10'd0, 10'd16, 10'd40);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (pim_start) seen = 1'b1;
            else tick();
        end
        check("abort_pim_start", 32'(seen), 1);
        tick(); tick();
        man_done = 1'b1;
        tick();                 // COMPUTE -> STORE
        man_done = 1'b0;
        tick();                 // first STORE write (mem[40])
        rst = 1'b1;
        tick();                 // reset edge during second STORE cycle
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_pim_a", 32'(|pim_a), 0);
        repeat (5) tick();
        check("abort_no_done", 32'(done_cnt - d0), 0);
        mem_chk("abort_mem40", 10'd40, 16'd16);
        mem_chk("abort_mem42", 10'd42, 16'd42);
        mem_chk("abort_mem48", 10'd48, 16'd48);

        // ---- stray pim_done in IDLE, then N=4 with a long compute stall ----
        d0 = done_cnt; p0 = pstart_cnt;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        tick();
        check("stray_busy", 32'(busy), 0);
        check("stray_no_done", 32'(done_cnt - d0), 0);
        check("stray_no_pstart", 32'(pstart_cnt - p0), 0);
        issue(3'd4, 10'd0, 10'd16, 10'd48);
        repeat (100) tick();
        check("stall_busy", 32'(busy), 1);
        check("stall_pstart_once", 32'(pstart_cnt - p0), 1);
        mem_chk("stall_mem48_untouched", 10'd48, 16'd48);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        wait_done(100, "stall_done_seen");
        tick();
        auto_resp = 1'b1;
        check("stall_done_count", 32'(done_cnt - d0), 1);
        mem_chk("stall_mem48", 10'd48, 16'd16);
        mem_chk("stall_mem63", 10'd63, 16'd46);

        // ---- host write with accepted start lands first; write in LOAD dropped ----
        host_addr = 10'd0; host_wdata = 16'd100; host_we = 1'b1;
        mat_n = 3'd4; src1 = 10'd0; src2 = 10'd16; dst = 10'd48; start = 1'b1;
        tick();
        start = 1'b0;
        host_addr = 10'd5; host_wdata = 16'hBEEF; host_we = 1'b1;
        tick();
        host_we = 1'b0;
        wait_done(100, "hw_done_seen");
        tick();
        mem_chk("hw_mem5_dropped", 10'd5, 16'd5);
        mem_chk("hw_mem0_written", 10'd0, 16'd100);
        mem_chk("hw_mem48", 10'd48, 16'd116);
        mem_chk("hw_mem53", 10'd53, 16'd26);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
